// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode front end. It fetches one 16-bit word per
// request into IR and presents its fields until a downstream stage consumes it.
module instr_fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  immHigh,
  output logic [3:0]  immLow,
  output logic [15:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        req_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      ir_pc   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over everything: any returning data is dropped, IR kept.
      state   <= FETCH;
      pc      <= redirect_pc;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state   <= FETCH;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
        FETCH: begin
          if (imem_ready) begin
            ir      <= imem_rdata;
            ir_pc   <= pc;
            pc      <= pc + PC_STEP;
            state   <= HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            state   <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign imem_req    = req_q;
  assign instr_valid = valid_q;
  assign opcode      = ir[15:12];
  assign rd          = ir[11:8];
  assign immHigh     = ir[7:4];
  assign immLow      = ir[3:0];
  assign pc_out      = ir_pc;

endmodule
